// File: rtl/rf_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_sched_pkg
// Shared widths and types for the register-file write-port scheduler.
//   ADDR_W      register address width (32 registers, x0 hardwired zero)
//   DATA_W      register write data width
//   regaddr_t   register address
//   data_t      register write data
//   buf_state_e occupancy of the one-entry long-unit holding buffer
// ---------------------------------------------------------------------------
package rf_sched_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] regaddr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler_if
// Bundles the issue check, WB request, long-unit result and RF write port.
//   iss_*    ID issue request (valid, rs1, rs2, rd, long) and stall reply
//   wb_*     pipeline WB write request (cannot be stalled)
//   lu_*     long-unit result (valid, rd, wd) and ready reply
//   rf_*     register file write port (RFWr, A3, WD)
// Modports: master = the surrounding pipeline / bench, slave = the scheduler.
// ---------------------------------------------------------------------------
interface rf_wb_scheduler_if;
  import rf_sched_pkg::*;

  logic     iss_valid;
  regaddr_t iss_rs1;
  regaddr_t iss_rs2;
  regaddr_t iss_rd;
  logic     iss_long;
  logic     iss_stall;

  logic     wb_we;
  regaddr_t wb_rd;
  data_t    wb_wd;

  logic     lu_valid;
  regaddr_t lu_rd;
  data_t    lu_wd;
  logic     lu_ready;

  logic     rf_we;
  regaddr_t rf_a3;
  data_t    rf_wd;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    output wb_we, wb_rd, wb_wd,
    output lu_valid, lu_rd, lu_wd,
    input  iss_stall, lu_ready, rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    input  wb_we, wb_rd, wb_wd,
    input  lu_valid, lu_rd, lu_wd,
    output iss_stall, lu_ready, rf_we, rf_a3, rf_wd
  );

endinterface

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Tracks registers with an outstanding long-unit write and the number of
// outstanding long-unit operations; produces the issue stall.
//   clk, rst          clock, asynchronous active-high reset
//   iss_*_i           issue request from ID
//   starve_force_i    force a bubble so WB frees the write port
//   drain_i/_rd_i     holding buffer leaves this cycle (its destination)
//   accept_i/_rd_i    long-unit result accepted this cycle (its destination)
//   iss_stall_o       hold ID, instruction not issued
// ---------------------------------------------------------------------------
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int MAX_PEND = 4,
  parameter int PEND_W   = $clog2(MAX_PEND + 1)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     iss_valid_i,
  input  regaddr_t iss_rs1_i,
  input  regaddr_t iss_rs2_i,
  input  regaddr_t iss_rd_i,
  input  logic     iss_long_i,
  input  logic     starve_force_i,
  input  logic     drain_i,
  input  regaddr_t drain_rd_i,
  input  logic     accept_i,
  input  regaddr_t accept_rd_i,
  output logic     iss_stall_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              hazard;
  logic              pend_full;
  logic              issue_long;

  // busy bit 0 is constant 0, so a zero operand never matches; no explicit
  // reg!=0 qualification is needed. Only registered busy is consulted, so a
  // drain releases its dependants one cycle later.
  assign hazard      = busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | busy_q[iss_rd_i];
  assign pend_full   = (pend_q == PEND_W'(MAX_PEND));
  assign iss_stall_o = iss_valid_i &
                       (rst | hazard | (iss_long_i & pend_full) | starve_force_i);
  assign issue_long  = iss_valid_i & ~iss_stall_o & iss_long_i;

  assign busy_d[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_d[gi] = (busy_q[gi] & ~(drain_i & (drain_rd_i == regaddr_t'(gi)))) |
                          (issue_long & (iss_rd_i == regaddr_t'(gi)));
    end
  endgenerate

  // A long issue to x0 still occupies a pending slot; its silent drain frees it.
  always_comb begin
    pend_d = pend_q;
    case ({issue_long, drain_i})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // Protocol sanity checks on the long unit; the datapath ignores them.
  a_accept_busy: assert property (@(posedge clk) disable iff (rst)
    (accept_i && (accept_rd_i != '0)) |-> busy_q[accept_rd_i]);
  a_pend_underflow: assert property (@(posedge clk) disable iff (rst)
    drain_i |-> (pend_q != '0));

endmodule

// File: rtl/rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler
// Shares the register file's single write port between the in-order WB stage
// and a long-latency unit. WB always wins; long-unit results wait in a
// one-entry buffer and drain when WB leaves the port idle. A starvation
// counter forces issue bubbles so that WB eventually goes idle.
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   rf_wb_scheduler_if.slave (issue, WB, long unit, RF write port)
// ---------------------------------------------------------------------------
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int MAX_PEND   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_wb_scheduler_if.slave   bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  buf_state_e            buf_state_q, buf_state_d;
  regaddr_t              buf_rd_q, buf_rd_d;
  data_t                 buf_wd_q, buf_wd_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic wb_owns;
  logic buf_full;
  logic drain;
  logic accept;
  logic starve_force;
  logic buf_sel;

  // WB to x0 is treated as idle so a buffered result may use the port.
  assign wb_owns  = bus.wb_we & (bus.wb_rd != '0);
  assign buf_full = (buf_state_q == BUF_FULL);
  // A buffered x0 result still drains (frees the slot) but never writes.
  assign drain    = buf_full & ~wb_owns;
  assign buf_sel  = ~rst & drain;

  assign bus.lu_ready = ~rst & (~buf_full | drain);
  assign accept       = bus.lu_valid & bus.lu_ready;

  // Counter saturates at STARVE_MAX, so force holds until the next drain.
  assign starve_force = (starve_cnt_q >= STARVE_W'(STARVE_MAX));

  // Zero-latency write mux; during reset WB passes straight through.
  assign bus.rf_we = rst ? bus.wb_we : (wb_owns | (drain & (buf_rd_q != '0)));
  assign bus.rf_a3 = buf_sel ? buf_rd_q : bus.wb_rd;
  assign bus.rf_wd = buf_sel ? buf_wd_q : bus.wb_wd;

  always_comb begin
    buf_state_d  = buf_state_q;
    buf_rd_d     = buf_rd_q;
    buf_wd_d     = buf_wd_q;
    starve_cnt_d = starve_cnt_q;

    // Accept may coincide with a drain; the new entry replaces the old one.
    if (accept) begin
      buf_state_d = BUF_FULL;
      buf_rd_d    = bus.lu_rd;
      buf_wd_d    = bus.lu_wd;
    end else if (drain) begin
      buf_state_d = BUF_EMPTY;
    end

    if (drain) begin
      starve_cnt_d = '0;
    end else if (buf_full && wb_owns && !starve_force) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_state_q  <= BUF_EMPTY;
      buf_rd_q     <= '0;
      buf_wd_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      buf_state_q  <= buf_state_d;
      buf_rd_q     <= buf_rd_d;
      buf_wd_q     <= buf_wd_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  rf_scoreboard #(
    .MAX_PEND (MAX_PEND)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .iss_valid_i    (bus.iss_valid),
    .iss_rs1_i      (bus.iss_rs1),
    .iss_rs2_i      (bus.iss_rs2),
    .iss_rd_i       (bus.iss_rd),
    .iss_long_i     (bus.iss_long),
    .starve_force_i (starve_force),
    .drain_i        (drain),
    .drain_rd_i     (buf_rd_q),
    .accept_i       (accept),
    .accept_rd_i    (bus.lu_rd),
    .iss_stall_o    (bus.iss_stall)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_scheduler
// Directed stimulus for rf_wb_scheduler. A transaction-level model (list of
// outstanding destinations, queue holding the buffered result, blocked-cycle
// count) predicts the outputs; a negedge process compares every cycle, and
// hand-computed literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_rf_wb_scheduler;
  import rf_sched_pkg::*;

  localparam int MAX_PEND   = 4;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;

  rf_wb_scheduler_if bus();

  rf_wb_scheduler #(
    .MAX_PEND   (MAX_PEND),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  int   m_pend[$];   // destinations of outstanding long ops (x0 included)
  ent_t m_buf[$];    // result waiting for the write port (at most one)
  int   m_starve;    // consecutive cycles a waiting result lost to WB

  typedef struct {
    logic        rf_we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        lu_ready;
    logic        stall;
    logic        drain;
    logic        accept;
    logic        issue_long;
  } pred_t;

  function automatic bit is_busy(int r);
    if (r == 0) return 1'b0;
    foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic pred_t predict();
    pred_t p;
    bit wb_port;
    bit waiting;
    bit hazard;
    wb_port = bus.wb_we && (bus.wb_rd != 0);
    waiting = (m_buf.size() != 0);
    p.drain = waiting && !wb_port && !rst;
    p.a3    = bus.wb_rd;
    p.wd    = bus.wb_wd;
    if (rst) begin
      p.rf_we    = bus.wb_we;
      p.lu_ready = 1'b0;
      p.stall    = bus.iss_valid;
    end else begin
      if (p.drain) begin
        p.a3 = m_buf[0].rd;
        p.wd = m_buf[0].wd;
      end
      p.rf_we    = wb_port || (p.drain && (m_buf[0].rd != 0));
      p.lu_ready = !waiting || p.drain;
      hazard = is_busy(int'(bus.iss_rs1)) || is_busy(int'(bus.iss_rs2)) ||
               is_busy(int'(bus.iss_rd));
      p.stall = bus.iss_valid && (hazard ||
                (bus.iss_long && (m_pend.size() >= MAX_PEND)) ||
                (m_starve >= STARVE_MAX));
    end
    p.accept     = bus.lu_valid && p.lu_ready;
    p.issue_long = !rst && bus.iss_valid && !p.stall && bus.iss_long;
    return p;
  endfunction

  always @(posedge clk) begin
    pred_t p;
    int idx;
    if (rst) begin
      m_pend.delete();
      m_buf.delete();
      m_starve = 0;
    end else begin
      p = predict();
      if (p.drain) begin
        idx = -1;
        for (int i = 0; i < m_pend.size(); i++)
          if (idx < 0 && m_pend[i] == int'(m_buf[0].rd)) idx = i;
        if (idx >= 0) m_pend.delete(idx);
        void'(m_buf.pop_front());
        m_starve = 0;
      end else if (m_buf.size() != 0) begin
        m_starve++;
      end
      if (p.issue_long) m_pend.push_back(int'(bus.iss_rd));
      if (p.accept) m_buf.push_back('{rd: bus.lu_rd, wd: bus.lu_wd});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    pred_t p;
    p = predict();
    n_checks++;
    if (bus.iss_stall !== p.stall) begin
      n_fail++;
      $display("FAIL cyc_iss_stall t=%0t got=%b exp=%b", $time, bus.iss_stall, p.stall);
    end
    n_checks++;
    if (bus.lu_ready !== p.lu_ready) begin
      n_fail++;
      $display("FAIL cyc_lu_ready t=%0t got=%b exp=%b", $time, bus.lu_ready, p.lu_ready);
    end
    n_checks++;
    if (bus.rf_we !== p.rf_we) begin
      n_fail++;
      $display("FAIL cyc_rf_we t=%0t got=%b exp=%b", $time, bus.rf_we, p.rf_we);
    end else if (p.rf_we) begin
      n_checks++;
      if (bus.rf_a3 !== p.a3 || bus.rf_wd !== p.wd) begin
        n_fail++;
        $display("FAIL cyc_rf_port t=%0t got=%0d/%h exp=%0d/%h",
                 $time, bus.rf_a3, bus.rf_wd, p.a3, p.wd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iss(input bit v, input int rs1, input int rs2, input int rd, input bit lng);
    bus.iss_valid = v;
    bus.iss_rs1   = 5'(rs1);
    bus.iss_rs2   = 5'(rs2);
    bus.iss_rd    = 5'(rd);
    bus.iss_long  = lng;
  endtask

  task automatic set_wb(input bit we, input int rd, input logic [31:0] wd);
    bus.wb_we = we;
    bus.wb_rd = 5'(rd);
    bus.wb_wd = wd;
  endtask

  task automatic set_lu(input bit v, input int rd, input logic [31:0] wd);
    bus.lu_valid = v;
    bus.lu_rd    = 5'(rd);
    bus.lu_wd    = wd;
  endtask

  task automatic idle_all();
    set_iss(0, 0, 0, 0, 0);
    set_wb(0, 0, 32'h0);
    set_lu(0, 0, 32'h0);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end else begin
      $display("check %s = %b ok", name, act);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    tick();

    // Behaviour while reset is held
    set_iss(1, 0, 0, 0, 0);
    set_wb(1, 0, 32'h5555_5555);
    set_lu(1, 3, 32'h0);
    #2;
    chk1("rst_iss_stall", bus.iss_stall, 1'b1);
    chk1("rst_lu_ready", bus.lu_ready, 1'b0);
    chk1("rst_rf_we_passthru", bus.rf_we, 1'b1);
    tick();
    idle_all();
    rst = 1'b0;
    #2;
    chk1("post_rst_lu_ready", bus.lu_ready, 1'b1);
    tick();

    // Long op and RAW stall
    set_iss(1, 0, 0, 7, 1);
    #2 chk1("t2_long_issue", bus.iss_stall, 1'b0);
    tick();
    set_iss(1, 7, 0, 0, 0);
    set_lu(1, 7, 32'hDEAD_BEEF);
    #2;
    chk1("t2_raw_stall", bus.iss_stall, 1'b1);
    chk1("t2_lu_ready", bus.lu_ready, 1'b1);
    tick();
    set_lu(0, 0, 32'h0);
    #2;
    chk1("t2_stall_on_drain", bus.iss_stall, 1'b1);
    chk1("t2_rf_we", bus.rf_we, 1'b1);
    chk32("t2_rf_a3", 32'(bus.rf_a3), 32'd7);
    chk32("t2_rf_wd", bus.rf_wd, 32'hDEAD_BEEF);
    tick();
    #2 chk1("t2_release", bus.iss_stall, 1'b0);
    tick();
    idle_all();

    // WB vs buffer conflict
    set_iss(1, 0, 0, 3, 1);
    tick();
    set_iss(0, 0, 0, 0, 0);
    set_lu(1, 3, 32'h0000_3333);
    tick();
    set_lu(0, 0, 32'h0);
    set_wb(1, 9, 32'h0000_9999);
    #2;
    chk32("t3_wb_a3", 32'(bus.rf_a3), 32'd9);
    chk32("t3_wb_wd", bus.rf_wd, 32'h0000_9999);
    chk1("t3_lu_blocked", bus.lu_ready, 1'b0);
    tick();
    set_wb(0, 0, 32'h0);
    #2;
    chk1("t3_drain_we", bus.rf_we, 1'b1);
    chk32("t3_drain_a3", 32'(bus.rf_a3), 32'd3);
    chk32("t3_drain_wd", bus.rf_wd, 32'h0000_3333);
    tick();

    // Starvation: WB holds the port for 10 cycles
    set_iss(1, 0, 0, 10, 1);
    tick();
    set_iss(0, 0, 0, 0, 0);
    set_lu(1, 10, 32'hA0A0_A0A0);
    tick();
    set_lu(0, 0, 32'h0);
    set_wb(1, 9, 32'h1111_0000);
    set_iss(1, 20, 0, 21, 0);
    for (int k = 0; k < 10; k++) begin
      #2;
      if (k == STARVE_MAX - 1) chk1("t4_not_yet_forced", bus.iss_stall, 1'b0);
      if (k == STARVE_MAX)     chk1("t4_forced", bus.iss_stall, 1'b1);
      tick();
    end
    set_wb(0, 0, 32'h0);
    #2;
    chk1("t4_forced_on_drain", bus.iss_stall, 1'b1);
    chk32("t4_drain_a3", 32'(bus.rf_a3), 32'd10);
    tick();
    #2 chk1("t4_force_cleared", bus.iss_stall, 1'b0);
    tick();
    idle_all();

    // Pending limit
    for (int r = 1; r <= 4; r++) begin
      set_iss(1, 0, 0, r, 1);
      #2 chk1("t5_fill_issue", bus.iss_stall, 1'b0);
      tick();
    end
    set_iss(1, 0, 0, 5, 1);
    set_lu(1, 1, 32'h0000_0011);
    #2 chk1("t5_limit_stall", bus.iss_stall, 1'b1);
    tick();
    set_lu(0, 0, 32'h0);
    #2;
    chk1("t5_stall_on_drain", bus.iss_stall, 1'b1);
    chk32("t5_drain_a3", 32'(bus.rf_a3), 32'd1);
    tick();
    #2 chk1("t5_fifth_issues", bus.iss_stall, 1'b0);
    tick();
    set_iss(0, 0, 0, 0, 0);
    for (int r = 2; r <= 5; r++) begin
      set_lu(1, r, 32'(r));
      tick();
    end
    set_lu(0, 0, 32'h0);
    tick();

    // x0 destination and WAW
    set_iss(1, 0, 0, 0, 1);
    #2 chk1("t6_x0_issue", bus.iss_stall, 1'b0);
    tick();
    set_iss(0, 0, 0, 0, 0);
    set_lu(1, 0, 32'h0000_1234);
    tick();
    set_lu(0, 0, 32'h0);
    set_wb(1, 0, 32'h0000_7777);
    #2;
    chk1("t6_silent_drain", bus.rf_we, 1'b0);
    chk1("t6_lu_ready", bus.lu_ready, 1'b1);
    tick();
    set_wb(0, 0, 32'h0);
    set_iss(1, 0, 0, 2, 1);
    tick();
    set_iss(1, 0, 0, 2, 0);
    #2 chk1("t6_waw_stall", bus.iss_stall, 1'b1);
    tick();
    set_iss(0, 0, 0, 0, 0);
    set_lu(1, 2, 32'h0000_0022);
    tick();
    set_lu(0, 0, 32'h0);
    tick();

    // Reset with a result buffered and busy[5] set
    set_iss(1, 0, 0, 5, 1);
    tick();
    set_iss(0, 0, 0, 0, 0);
    set_lu(1, 5, 32'h0000_0055);
    tick();
    set_lu(0, 0, 32'h0);
    set_wb(1, 9, 32'h0000_0099);
    tick();
    rst = 1'b1;
    #2;
    chk1("t1_rst_lu_ready", bus.lu_ready, 1'b0);
    chk1("t1_rst_rf_we", bus.rf_we, 1'b1);
    tick();
    rst = 1'b0;
    set_wb(0, 0, 32'h0);
    set_iss(1, 5, 0, 0, 0);
    #2;
    chk1("t1_busy_cleared", bus.iss_stall, 1'b0);
    chk1("t1_buffer_dropped", bus.rf_we, 1'b0);
    chk1("t1_lu_ready_after", bus.lu_ready, 1'b1);
    tick();
    idle_all();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
